// File: rtl/catapult_shim_if.sv
// rtl/catapult_shim_if.sv - PCIe stream and softreg channel bundle between Catapult shell and shim
interface catapult_shim_if #(
  parameter int PCIE_WIDTH         = 128,
  parameter int SOFTREG_ADDR_WIDTH = 32,
  parameter int SOFTREG_DATA_WIDTH = 64
);
  logic                          io_pcie_in_valid;
  logic                          io_pcie_in_ready;
  logic [PCIE_WIDTH-1:0]         io_pcie_in_bits;
  logic                          io_pcie_out_valid;
  logic                          io_pcie_out_ready;
  logic [PCIE_WIDTH-1:0]         io_pcie_out_bits;
  logic                          io_softreg_req_valid;
  logic                          io_softreg_req_ready;
  logic [SOFTREG_ADDR_WIDTH-1:0] io_softreg_req_bits_addr;
  logic [SOFTREG_DATA_WIDTH-1:0] io_softreg_req_bits_wdata;
  logic                          io_softreg_req_bits_wr;
  logic                          io_softreg_resp_valid;
  logic                          io_softreg_resp_ready;
  logic [SOFTREG_DATA_WIDTH-1:0] io_softreg_resp_bits_rdata;

  modport slave (
    input  io_pcie_in_valid, io_pcie_in_bits, io_pcie_out_ready,
    input  io_softreg_req_valid, io_softreg_req_bits_addr, io_softreg_req_bits_wdata,
    input  io_softreg_req_bits_wr, io_softreg_resp_ready,
    output io_pcie_in_ready, io_pcie_out_valid, io_pcie_out_bits,
    output io_softreg_req_ready, io_softreg_resp_valid, io_softreg_resp_bits_rdata
  );

  modport master (
    output io_pcie_in_valid, io_pcie_in_bits, io_pcie_out_ready,
    output io_softreg_req_valid, io_softreg_req_bits_addr, io_softreg_req_bits_wdata,
    output io_softreg_req_bits_wr, io_softreg_resp_ready,
    input  io_pcie_in_ready, io_pcie_out_valid, io_pcie_out_bits,
    input  io_softreg_req_ready, io_softreg_resp_valid, io_softreg_resp_bits_rdata
  );
endinterface

// File: rtl/catapult_shim.sv
// rtl/catapult_shim.sv - softreg register file plus buffered PCIe loopback path
module catapult_shim #(
  parameter int PCIE_WIDTH         = 128,
  parameter int SOFTREG_ADDR_WIDTH = 32,
  parameter int SOFTREG_DATA_WIDTH = 64,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic            clock,
  input  logic            reset,
  catapult_shim_if.slave  bus
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int DW  = SOFTREG_DATA_WIDTH;
  localparam int ADW = SOFTREG_ADDR_WIDTH;

  logic                  active_q;
  logic [PCIE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic                  full, empty, push, pop, in_ready, out_valid;
  logic                  loop_en_q, loop_en_d;
  logic [DW-1:0]         scratch_q [8];
  logic [DW-1:0]         in_beats_q, in_beats_d, out_beats_q, out_beats_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DW-1:0]         rdata_q, rdata_d, rd_mux;
  logic                  req_ready, req_fire, wr_fire, rd_fire, resp_fire, flush;
  logic                  sel_scratch, sel_ctrl, sel_status, sel_in, sel_out;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = count[AW];
  assign empty     = (count == '0);
  assign in_ready  = active_q & ~full;
  assign out_valid = active_q & loop_en_q & ~empty;
  assign push      = bus.io_pcie_in_valid & in_ready;
  assign pop       = out_valid & bus.io_pcie_out_ready;

  assign bus.io_pcie_in_ready  = in_ready;
  assign bus.io_pcie_out_valid = out_valid;
  assign bus.io_pcie_out_bits  = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

  assign req_ready = active_q & ~resp_valid_q;
  assign req_fire  = bus.io_softreg_req_valid & req_ready;
  assign wr_fire   = req_fire & bus.io_softreg_req_bits_wr;
  assign rd_fire   = req_fire & ~bus.io_softreg_req_bits_wr;
  assign resp_fire = resp_valid_q & bus.io_softreg_resp_ready;

  assign bus.io_softreg_req_ready       = req_ready;
  assign bus.io_softreg_resp_valid      = resp_valid_q;
  assign bus.io_softreg_resp_bits_rdata = rdata_q;

  assign sel_scratch = (bus.io_softreg_req_bits_addr[ADW-1:3] == '0);
  assign sel_ctrl    = (bus.io_softreg_req_bits_addr == ADW'(8));
  assign sel_status  = (bus.io_softreg_req_bits_addr == ADW'(9));
  assign sel_in      = (bus.io_softreg_req_bits_addr == ADW'(10));
  assign sel_out     = (bus.io_softreg_req_bits_addr == ADW'(11));
  assign flush       = wr_fire & sel_ctrl & bus.io_softreg_req_bits_wdata[1];

  always_comb begin
    rd_mux = '0;
    if (sel_scratch) begin
      rd_mux = scratch_q[bus.io_softreg_req_bits_addr[2:0]];
    end else if (sel_ctrl) begin
      rd_mux[0] = loop_en_q;
    end else if (sel_status) begin
      rd_mux[15:0] = 16'(count);
      rd_mux[16]   = full;
      rd_mux[17]   = empty;
    end else if (sel_in) begin
      rd_mux = in_beats_q;
    end else if (sel_out) begin
      rd_mux = out_beats_q;
    end
  end

  // Flush discards a same-edge push/pop, but the beat counters still see it.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    loop_en_d    = loop_en_q;
    in_beats_d   = in_beats_q;
    out_beats_d  = out_beats_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    if (wr_fire && sel_ctrl) loop_en_d = bus.io_softreg_req_bits_wdata[0];
    if (wr_fire && sel_in)   in_beats_d = '0;
    else if (push)           in_beats_d = in_beats_q + DW'(1);
    if (wr_fire && sel_out)  out_beats_d = '0;
    else if (pop)            out_beats_d = out_beats_q + DW'(1);
    if (rd_fire) begin
      resp_valid_d = 1'b1;
      rdata_d      = rd_mux;
    end else if (resp_fire) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      loop_en_q    <= 1'b0;
      in_beats_q   <= '0;
      out_beats_q  <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      for (int i = 0; i < 8; i++) scratch_q[i] <= '0;
    end else begin
      active_q     <= 1'b1;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      loop_en_q    <= loop_en_d;
      in_beats_q   <= in_beats_d;
      out_beats_q  <= out_beats_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      if (wr_fire && sel_scratch)
        scratch_q[bus.io_softreg_req_bits_addr[2:0]] <= bus.io_softreg_req_bits_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.io_pcie_in_bits;
  end
endmodule

// File: tb/tb_catapult_shim.sv
// tb/tb_catapult_shim.sv - randomized self-checking bench for catapult_shim
module tb_catapult_shim;
  localparam int PW    = 128;
  localparam int ADW   = 32;
  localparam int DW    = 64;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  catapult_shim_if #(.PCIE_WIDTH(PW), .SOFTREG_ADDR_WIDTH(ADW), .SOFTREG_DATA_WIDTH(DW)) bus ();
  catapult_shim #(.PCIE_WIDTH(PW), .SOFTREG_ADDR_WIDTH(ADW), .SOFTREG_DATA_WIDTH(DW),
                  .FIFO_DEPTH(DEPTH)) dut (.clock(clk), .reset(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] m_scratch [8];
  bit            m_loop;
  logic [PW-1:0] m_fifo [$];
  logic [DW-1:0] m_in_cnt, m_out_cnt;
  logic [PW-1:0] out_log [$];

  task automatic check_eq(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [ADW-1:0] a);
    logic [DW-1:0] s;
    s = '0;
    if (a < 8) return m_scratch[a[2:0]];
    case (a)
      8:  s[0] = m_loop;
      9:  begin
        s[15:0] = 16'(m_fifo.size());
        s[16]   = (m_fifo.size() == DEPTH);
        s[17]   = (m_fifo.size() == 0);
      end
      10: s = m_in_cnt;
      11: s = m_out_cnt;
      default: s = '0;
    endcase
    return s;
  endfunction

  task automatic model_write(input logic [ADW-1:0] a, input logic [DW-1:0] d);
    if (a < 8) m_scratch[a[2:0]] = d;
    else if (a == 8) begin
      m_loop = d[0];
      if (d[1]) m_fifo.delete();
    end
    else if (a == 10) m_in_cnt = '0;
    else if (a == 11) m_out_cnt = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_scratch[i] = '0;
    m_loop = 1'b0;
    m_fifo.delete();
    m_in_cnt = '0;
    m_out_cnt = '0;
  endtask

  task automatic idle_inputs();
    bus.io_pcie_in_valid          = 1'b0;
    bus.io_pcie_in_bits           = '0;
    bus.io_pcie_out_ready         = 1'b0;
    bus.io_softreg_req_valid      = 1'b0;
    bus.io_softreg_req_bits_addr  = '0;
    bus.io_softreg_req_bits_wdata = '0;
    bus.io_softreg_req_bits_wr    = 1'b0;
    bus.io_softreg_resp_ready     = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_in_ready"},   bus.io_pcie_in_ready, 0);
    check_eq({tag, "_out_valid"},  bus.io_pcie_out_valid, 0);
    check_eq({tag, "_out_bits"},   bus.io_pcie_out_bits, 0);
    check_eq({tag, "_req_ready"},  bus.io_softreg_req_ready, 0);
    check_eq({tag, "_resp_valid"}, bus.io_softreg_resp_valid, 0);
    check_eq({tag, "_rdata"},      bus.io_softreg_resp_bits_rdata, 0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    idle_inputs();
    repeat (cycles) begin
      step();
      check_outputs_zero("rst");
    end
    rst = 1'b0;
    #1;
    check_outputs_zero("post_rst");
    step();
    model_reset();
    check_eq("rst_in_ready_up", bus.io_pcie_in_ready, 1);
    check_eq("rst_req_ready_up", bus.io_softreg_req_ready, 1);
  endtask

  task automatic sr_write(input logic [ADW-1:0] a, input logic [DW-1:0] d);
    bus.io_softreg_req_valid      = 1'b1;
    bus.io_softreg_req_bits_addr  = a;
    bus.io_softreg_req_bits_wdata = d;
    bus.io_softreg_req_bits_wr    = 1'b1;
    #1;
    check_eq("wr_req_ready", bus.io_softreg_req_ready, 1);
    @(posedge clk);
    model_write(a, d);
    #1;
    bus.io_softreg_req_valid   = 1'b0;
    bus.io_softreg_req_bits_wr = 1'b0;
  endtask

  // Write request on the same edge as a PCIe push (loopback must be off).
  task automatic sr_write_push(input logic [ADW-1:0] a, input logic [DW-1:0] d, input logic [PW-1:0] v);
    bit can_push;
    bus.io_softreg_req_valid      = 1'b1;
    bus.io_softreg_req_bits_addr  = a;
    bus.io_softreg_req_bits_wdata = d;
    bus.io_softreg_req_bits_wr    = 1'b1;
    bus.io_pcie_in_valid          = 1'b1;
    bus.io_pcie_in_bits           = v;
    #1;
    can_push = (m_fifo.size() < DEPTH);
    check_eq("wp_in_ready", bus.io_pcie_in_ready, can_push);
    @(posedge clk);
    if (can_push) begin
      m_fifo.push_back(v);
      m_in_cnt++;
    end
    model_write(a, d);
    #1;
    idle_inputs();
  endtask

  task automatic sr_read(input logic [ADW-1:0] a, input int hold, input string tag);
    logic [DW-1:0] exp;
    exp = model_read(a);
    bus.io_softreg_req_valid     = 1'b1;
    bus.io_softreg_req_bits_addr = a;
    bus.io_softreg_req_bits_wr   = 1'b0;
    #1;
    check_eq({tag, "_req_ready"}, bus.io_softreg_req_ready, 1);
    @(posedge clk);
    #1;
    bus.io_softreg_req_valid = 1'b0;
    check_eq({tag, "_resp_valid"}, bus.io_softreg_resp_valid, 1);
    check_eq({tag, "_rdata"}, bus.io_softreg_resp_bits_rdata, exp);
    check_eq({tag, "_busy"}, bus.io_softreg_req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq({tag, "_hold_valid"}, bus.io_softreg_resp_valid, 1);
      check_eq({tag, "_hold_rdata"}, bus.io_softreg_resp_bits_rdata, exp);
      check_eq({tag, "_hold_busy"}, bus.io_softreg_req_ready, 0);
    end
    bus.io_softreg_resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.io_softreg_resp_ready = 1'b0;
    check_eq({tag, "_resp_done"}, bus.io_softreg_resp_valid, 0);
    check_eq({tag, "_req_back"}, bus.io_softreg_req_ready, 1);
  endtask

  // Send n beats base, base+1, ... with random out_ready; optionally wait for drain.
  task automatic run_pcie(input int n, input logic [PW-1:0] base, input int pct, input bit drain,
                          input int max_cyc, output int sent);
    int cyc;
    bit exp_ov, do_push, do_pop;
    logic [PW-1:0] obits;
    sent = 0;
    cyc  = 0;
    while (!(sent >= n && (!drain || m_fifo.size() == 0)) && cyc < max_cyc) begin
      cyc++;
      bus.io_pcie_in_valid  = (sent < n);
      bus.io_pcie_in_bits   = base + PW'(sent);
      bus.io_pcie_out_ready = ($urandom_range(99) < pct);
      #1;
      exp_ov = m_loop && (m_fifo.size() > 0);
      check_eq("pcie_in_ready", bus.io_pcie_in_ready, m_fifo.size() < DEPTH);
      check_eq("pcie_out_valid", bus.io_pcie_out_valid, exp_ov);
      if (exp_ov) check_eq("pcie_out_bits", bus.io_pcie_out_bits, m_fifo[0]);
      obits   = bus.io_pcie_out_bits;
      do_push = bus.io_pcie_in_valid && (m_fifo.size() < DEPTH);
      do_pop  = exp_ov && bus.io_pcie_out_ready;
      @(posedge clk);
      if (do_pop) begin
        void'(m_fifo.pop_front());
        m_out_cnt++;
        out_log.push_back(obits);
      end
      if (do_push) begin
        m_fifo.push_back(bus.io_pcie_in_bits);
        m_in_cnt++;
        sent++;
      end
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    int sent, n;
    bit lp;
    idle_inputs();
    model_reset();
    do_reset(3);

    sr_read(8, 0, "rst_ctrl");
    sr_read(9, 0, "rst_status");
    sr_read(10, 0, "rst_in_beats");

    sr_write(3, 64'hDEADBEEF_CAFEF00D);
    sr_read(3, 5, "scratch3");

    sr_write(32'h40, 64'h1234);
    sr_read(32'h40, 1, "unmapped");
    sr_read(9, 0, "status_after_unmapped");

    sr_write(1, 64'h0000_0000_0000_0001);
    sr_read(10, 0, "in_beats_idle");
    sr_write(8, 64'h1);
    out_log.delete();
    run_pcie(20, 0, 60, 1'b1, 500, sent);
    check_eq("loop_sent", sent, 20);
    check_eq("loop_out_count", out_log.size(), 20);
    for (int i = 0; i < out_log.size(); i++) check_eq("loop_order", out_log[i], i);
    sr_read(10, 0, "loop_in_beats");
    sr_read(11, 0, "loop_out_beats");

    sr_write(8, 64'h0);
    out_log.delete();
    run_pcie(10, 100, 100, 1'b0, 14, sent);
    check_eq("full_sent", sent, 8);
    sr_read(9, 2, "full_status");
    sr_write(8, 64'h1);
    run_pcie(2, 108, 100, 1'b1, 100, sent);
    check_eq("full_rest_sent", sent, 2);
    check_eq("full_out_count", out_log.size(), 10);
    for (int i = 0; i < out_log.size(); i++) check_eq("full_order", out_log[i], 100 + i);

    sr_write(8, 64'h0);
    sr_write(10, 64'h0);
    run_pcie(5, 200, 0, 1'b0, 20, sent);
    sr_write(8, 64'h2);
    sr_read(9, 0, "flush_status");
    sr_read(8, 0, "flush_ctrl");
    sr_read(10, 0, "flush_in_beats");
    sr_write(10, 64'h55);
    sr_read(10, 0, "clear_in_beats");

    sr_write_push(10, 64'h0, 300);
    sr_read(10, 0, "clear_wins_in_beats");
    sr_read(9, 0, "clear_push_status");
    sr_write_push(8, 64'h2, 301);
    sr_read(9, 0, "flush_push_status");
    sr_read(10, 0, "flush_push_in_beats");

    run_pcie(3, 400, 0, 1'b0, 10, sent);
    bus.io_softreg_req_valid     = 1'b1;
    bus.io_softreg_req_bits_addr = 9;
    bus.io_softreg_req_bits_wr   = 1'b0;
    step();
    bus.io_softreg_req_valid = 1'b0;
    check_eq("midrst_resp_pending", bus.io_softreg_resp_valid, 1);
    rst = 1'b1;
    step();
    check_eq("midrst_resp_dropped", bus.io_softreg_resp_valid, 0);
    check_eq("midrst_in_ready", bus.io_pcie_in_ready, 0);
    rst = 1'b0;
    step();
    model_reset();
    sr_read(9, 0, "midrst_status");
    sr_read(3, 0, "midrst_scratch");

    for (int it = 0; it < 10; it++) begin
      lp = 1'($urandom_range(1));
      sr_write(8, {62'b0, 1'b1, lp});
      n = lp ? int'($urandom_range(1, 25)) : int'($urandom_range(0, 8));
      run_pcie(n, {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(20, 100)), lp, 600, sent);
      check_eq("rand_sent", sent, n);
      sr_write(ADW'($urandom_range(0, 15)), {$urandom, $urandom});
      sr_read(ADW'($urandom_range(0, 12)), int'($urandom_range(0, 3)), "rand_reg");
      sr_read(9, 0, "rand_status");
      sr_read(10, 0, "rand_in_beats");
      sr_read(11, 0, "rand_out_beats");
      if ($urandom_range(3) == 0) sr_write(ADW'($urandom_range(10, 11)), {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
